// File: rtl/divider_pkg.sv
// Shared constants for the 4-bit unsigned divider tile.
//   W         : operand/result width (fixed at 4)
//   DZ_QUOT   : quotient reported on divide-by-zero
//   *_LSB     : field positions inside the packed ui_in / uo_out buses
package divider_pkg;

  localparam int unsigned W = 4;

  localparam logic [W-1:0] DZ_QUOT = 4'hF;

  // ui_in = {A, B}
  localparam int unsigned UI_A_LSB = 4;
  localparam int unsigned UI_B_LSB = 0;

  // uo_out = {Q, R}
  localparam int unsigned UO_Q_LSB = 4;
  localparam int unsigned UO_R_LSB = 0;

endpackage

// File: rtl/tt_um_unsigned_divider_if.sv
// Bundle of the Tiny Tapeout user-tile buses around the divider.
//   ena     : tile enable
//   ui_in   : {A[3:0], B[3:0]}
//   uio_in  : unused by the divider
//   uo_out  : {Q[3:0], R[3:0]}
//   uio_out : {7'b0, dz}
//   uio_oe  : output-enable for uio (only bit 0)
// master drives the operands (harness side); slave is the divider tile.
interface tt_um_unsigned_divider_if;

  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena,
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ena,
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );

endinterface

// File: rtl/div_restore_stage.sv
// One restoring-division step.
//   rem_i   : partial remainder from the previous stage (W bits, < div_i)
//   a_bit_i : next dividend bit, MSB first
//   div_i   : divisor B
//   q_o     : quotient bit for this step
//   rem_o   : partial remainder passed to the next stage
module div_restore_stage
  import divider_pkg::*;
(
  input  logic [W-1:0] rem_i,
  input  logic         a_bit_i,
  input  logic [W-1:0] div_i,
  output logic         q_o,
  output logic [W-1:0] rem_o
);

  logic [W:0] shifted;
  logic [W:0] diff;

  always_comb begin
    shifted = {rem_i, a_bit_i};
    diff    = shifted - {1'b0, div_i};
    // With rem_i < div_i the shifted value is at most 2*div_i-1, so a
    // non-negative difference always fits in W bits and the top bit is
    // a reliable sign.
    q_o   = ~diff[W];
    rem_o = q_o ? diff[W-1:0] : shifted[W-1:0];
  end

endmodule

// File: rtl/tt_um_unsigned_divider.sv
// Tiny Tapeout tile: 4-bit unsigned divider with a registered output.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   ena     : registers update only when 1
//   ui_in   : [7:4] dividend A, [3:0] divisor B
//   uio_in  : ignored
//   uo_out  : [7:4] quotient Q, [3:0] remainder R (registered, 1-cycle latency)
//   uio_out : [0] divide-by-zero flag (registered), [7:1] zero
//   uio_oe  : constant 8'h01
module tt_um_unsigned_divider
  import divider_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] quot;
  logic [W-1:0] rem_chain [W+1];
  logic         div_zero;

  logic [7:0]   uo_d, uo_q;
  logic         dz_d, dz_q;

  logic         unused_uio_in;
  assign unused_uio_in = ^uio_in;

  assign op_a = ui_in[UI_A_LSB +: W];
  assign op_b = ui_in[UI_B_LSB +: W];

  assign rem_chain[0] = '0;

  for (genvar i = 0; i < W; i++) begin : g_stage
    div_restore_stage u_stage (
      .rem_i   (rem_chain[i]),
      .a_bit_i (op_a[W-1-i]),
      .div_i   (op_b),
      .q_o     (quot[W-1-i]),
      .rem_o   (rem_chain[i+1])
    );
  end

  assign div_zero = (op_b == '0);

  always_comb begin
    uo_d = uo_q;
    dz_d = dz_q;
    if (ena) begin
      dz_d = div_zero;
      if (div_zero) begin
        uo_d[UO_Q_LSB +: W] = DZ_QUOT;
        uo_d[UO_R_LSB +: W] = op_a;
      end else begin
        uo_d[UO_Q_LSB +: W] = quot;
        uo_d[UO_R_LSB +: W] = rem_chain[W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uo_q <= 8'h00;
      dz_q <= 1'b0;
    end else begin
      uo_q <= uo_d;
      dz_q <= dz_d;
    end
  end

  assign uo_out  = uo_q;
  assign uio_out = {7'b0, dz_q};
  assign uio_oe  = 8'h01;

endmodule

// File: tb/tb_tt_um_unsigned_divider.sv
module tb_tt_um_unsigned_divider;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  tt_um_unsigned_divider_if bus ();

  always #5 clk = ~clk;

  tt_um_unsigned_divider dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (bus.ena),
    .ui_in   (bus.ui_in),
    .uio_in  (bus.uio_in),
    .uo_out  (bus.uo_out),
    .uio_out (bus.uio_out),
    .uio_oe  (bus.uio_oe)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division with the divide-by-zero rule.
  function automatic logic [7:0] ref_out(input logic [7:0] v);
    int a, b;
    a = int'(v[7:4]);
    b = int'(v[3:0]);
    if (b == 0) return {4'hF, v[7:4]};
    return {4'(a / b), 4'(a % b)};
  endfunction

  function automatic logic [7:0] ref_dz(input logic [7:0] v);
    return {7'b0, (v[3:0] == 4'h0)};
  endfunction

  task automatic apply(input logic [7:0] v);
    @(negedge clk);
    bus.ui_in = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] expect_out;
    logic [7:0] expect_dz;
    logic [7:0] v;
    int a, b, q, r;

    bus.ena    = 1'b1;
    bus.uio_in = 8'h00;
    bus.ui_in  = 8'hB3;
    rst_n      = 1'b0;
    #1;
    check("reset_uo", bus.uo_out, 8'h00);
    check("reset_uio", bus.uio_out, 8'h00);
    @(posedge clk);
    #1;
    check("reset_hold_uo", bus.uo_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    apply(8'hB3);
    check("div_11_3", bus.uo_out, 8'h32);
    check("div_11_3_dz", bus.uio_out, 8'h00);
    apply(8'hF1);
    check("div_15_1", bus.uo_out, 8'hF0);
    apply(8'h5A);
    check("div_5_10", bus.uo_out, 8'h05);
    apply(8'h90);
    check("div_9_0", bus.uo_out, 8'hF9);
    check("div_9_0_dz", bus.uio_out, 8'h01);
    check("uio_oe", bus.uio_oe, 8'h01);
    apply(8'h07);
    check("div_0_7", bus.uo_out, 8'h00);

    // Hold with ena low
    apply(8'hD4);
    expect_out = ref_out(8'hD4);
    check("pre_hold", bus.uo_out, expect_out);
    @(negedge clk);
    bus.ena = 1'b0;
    for (int i = 0; i < 6; i++) begin
      apply(8'($urandom));
      check("hold_uo", bus.uo_out, expect_out);
      check("hold_dz", bus.uio_out, 8'h00);
    end
    @(negedge clk);
    bus.ena = 1'b1;

    // Asynchronous reset mid-operation
    apply(8'hE0);
    check("pre_rst_dz", bus.uio_out, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_uo", bus.uo_out, 8'h00);
    check("async_rst_uio", bus.uio_out, 8'h00);
    apply(8'hC5);
    check("in_rst_uo", bus.uo_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    apply(8'hC5);
    check("post_rst", bus.uo_out, ref_out(8'hC5));

    // Exhaustive sweep: arithmetic invariants plus exact model compare
    for (int i = 0; i < 256; i++) begin
      v = 8'(i);
      apply(v);
      a = int'(v[7:4]);
      b = int'(v[3:0]);
      q = int'(bus.uo_out[7:4]);
      r = int'(bus.uo_out[3:0]);
      if (b == 0) begin
        check("sweep_dz_out", bus.uo_out, {4'hF, v[7:4]});
        check("sweep_dz_flag", bus.uio_out, 8'h01);
      end else begin
        check("sweep_qbr", 8'(q * b + r), 8'(a));
        check("sweep_rltb", 8'(r < b), 8'h01);
        check("sweep_noflag", bus.uio_out, 8'h00);
      end
      check("sweep_model", bus.uo_out, ref_out(v));
    end

    // Random operands with random enable, tracked by the model
    expect_out = ref_out(8'hFF);
    expect_dz  = ref_dz(8'hFF);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      bus.ena   = 1'($urandom_range(0, 3) != 0);
      bus.ui_in = 8'($urandom);
      if (bus.ena) begin
        expect_out = ref_out(bus.ui_in);
        expect_dz  = ref_dz(bus.ui_in);
      end
      @(posedge clk);
      #1;
      check("rand_uo", bus.uo_out, expect_out);
      check("rand_dz", bus.uio_out, expect_dz);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
